axi_mem_rr_arbiter: RTL

- Two-master to one-slave AXI4 arbiter for the uncore memory path.
- Shares the single memory AXI port (into the address mapper and PS DDR) between master 0 (core memory port) and master 1 (framebuffer/DMA reader).
- Read and write directions are arbitrated independently, round-robin, with one burst in flight per direction.
- Grant is held until the burst completes: RLAST for reads, B handshake for writes.

---
 rtl/axi_pkg.sv | 10 +
 rtl/axi_mem_rr_arbiter_rr_arb2.sv | 13 +
 rtl/axi_mem_rr_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and arbiter FSM state types for the uncore memory path.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

endpackage

// File: rtl/axi_mem_rr_arbiter_rr_arb2.sv
// Two-way round-robin pick: ptr_i names the master that wins a tie.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic en_i,
  input  logic ptr_i,
  output logic gnt_o
);

  // A sole requester always wins; the pointer only breaks ties.
  assign gnt_o = en_i & ((req0_i & req1_i) ? ptr_i : req1_i);

endmodule

// File: rtl/axi_mem_rr_arbiter.sv
// Two-master to one-slave AXI4 arbiter; reads and writes arbitrated independently,
// one burst per direction, grant held until RLAST handshake / B handshake.
module axi_mem_rr_arbiter
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8
) (
  input  logic                  uncoreclk,
  input  logic                  uncorerst,
  // master 0
  input  logic [ID_W-1:0]       s0_awid,
  input  logic [ADDR_W-1:0]     s0_awaddr,
  input  logic [7:0]            s0_awlen,
  input  logic [2:0]            s0_awsize,
  input  logic [1:0]            s0_awburst,
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [DATA_W-1:0]     s0_wdata,
  input  logic [DATA_W/8-1:0]   s0_wstrb,
  input  logic                  s0_wlast,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  output logic [ID_W-1:0]       s0_bid,
  output logic [1:0]            s0_bresp,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  input  logic [ID_W-1:0]       s0_arid,
  input  logic [ADDR_W-1:0]     s0_araddr,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  output logic [ID_W-1:0]       s0_rid,
  output logic [DATA_W-1:0]     s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  // master 1
  input  logic [ID_W-1:0]       s1_awid,
  input  logic [ADDR_W-1:0]     s1_awaddr,
  input  logic [7:0]            s1_awlen,
  input  logic [2:0]            s1_awsize,
  input  logic [1:0]            s1_awburst,
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [DATA_W-1:0]     s1_wdata,
  input  logic [DATA_W/8-1:0]   s1_wstrb,
  input  logic                  s1_wlast,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  output logic [ID_W-1:0]       s1_bid,
  output logic [1:0]            s1_bresp,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  input  logic [ID_W-1:0]       s1_arid,
  input  logic [ADDR_W-1:0]     s1_araddr,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  output logic [ID_W-1:0]       s1_rid,
  output logic [DATA_W-1:0]     s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  // slave port
  output logic [ID_W-1:0]       m_awid,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [ID_W-1:0]       m_bid,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ID_W-1:0]       m_arid,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_W-1:0]       m_rid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  rd_state_e rState_q, rState_d;
  wr_state_e wState_q, wState_d;
  logic      rGr_q, rGr_d, rPtr_q, rPtr_d;
  logic      wGr_q, wGr_d, wPtr_q, wPtr_d;
  logic      rArbGnt, wArbGnt;

  rr_arb2 uRdArb (
    .req0_i (s0_arvalid),
    .req1_i (s1_arvalid),
    .en_i   (rState_q == R_IDLE),
    .ptr_i  (rPtr_q),
    .gnt_o  (rArbGnt)
  );

  rr_arb2 uWrArb (
    .req0_i (s0_awvalid),
    .req1_i (s1_awvalid),
    .en_i   (wState_q == W_IDLE),
    .ptr_i  (wPtr_q),
    .gnt_o  (wArbGnt)
  );

  always_ff @(posedge uncoreclk or posedge uncorerst) begin
    if (uncorerst) begin
      rState_q <= R_IDLE;
      rGr_q    <= 1'b0;
      rPtr_q   <= 1'b0;
      wState_q <= W_IDLE;
      wGr_q    <= 1'b0;
      wPtr_q   <= 1'b0;
    end else begin
      rState_q <= rState_d;
      rGr_q    <= rGr_d;
      rPtr_q   <= rPtr_d;
      wState_q <= wState_d;
      wGr_q    <= wGr_d;
      wPtr_q   <= wPtr_d;
    end
  end

  // On burst completion the pointer moves to the master that was not just served.
  always_comb begin
    rState_d = rState_q;
    rGr_d    = rGr_q;
    rPtr_d   = rPtr_q;
    case (rState_q)
      R_IDLE: if (s0_arvalid || s1_arvalid) begin
        rGr_d    = rArbGnt;
        rState_d = R_ADDR;
      end
      R_ADDR: if (m_arvalid && m_arready) rState_d = R_DATA;
      R_DATA: if (m_rvalid && m_rready && m_rlast) begin
        rPtr_d   = ~rGr_q;
        rState_d = R_IDLE;
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_comb begin
    wState_d = wState_q;
    wGr_d    = wGr_q;
    wPtr_d   = wPtr_q;
    case (wState_q)
      W_IDLE: if (s0_awvalid || s1_awvalid) begin
        wGr_d    = wArbGnt;
        wState_d = W_ADDR;
      end
      W_ADDR: if (m_awvalid && m_awready) wState_d = W_DATA;
      W_DATA: if (m_wvalid && m_wready && m_wlast) wState_d = W_RESP;
      W_RESP: if (m_bvalid && m_bready) begin
        wPtr_d   = ~wGr_q;
        wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Payloads follow the grant; only the valid/ready strobes are gated by state.
  assign m_arid    = rGr_q ? s1_arid    : s0_arid;
  assign m_araddr  = rGr_q ? s1_araddr  : s0_araddr;
  assign m_arlen   = rGr_q ? s1_arlen   : s0_arlen;
  assign m_arsize  = rGr_q ? s1_arsize  : s0_arsize;
  assign m_arburst = rGr_q ? s1_arburst : s0_arburst;
  assign m_arvalid = (rState_q == R_ADDR) && (rGr_q ? s1_arvalid : s0_arvalid);
  assign s0_arready = (rState_q == R_ADDR) && !rGr_q && m_arready;
  assign s1_arready = (rState_q == R_ADDR) &&  rGr_q && m_arready;

  assign m_rready  = (rState_q == R_DATA) && (rGr_q ? s1_rready : s0_rready);
  assign s0_rvalid = (rState_q == R_DATA) && !rGr_q && m_rvalid;
  assign s1_rvalid = (rState_q == R_DATA) &&  rGr_q && m_rvalid;
  assign s0_rid    = m_rid;
  assign s1_rid    = m_rid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;

  assign m_awid    = wGr_q ? s1_awid    : s0_awid;
  assign m_awaddr  = wGr_q ? s1_awaddr  : s0_awaddr;
  assign m_awlen   = wGr_q ? s1_awlen   : s0_awlen;
  assign m_awsize  = wGr_q ? s1_awsize  : s0_awsize;
  assign m_awburst = wGr_q ? s1_awburst : s0_awburst;
  assign m_awvalid = (wState_q == W_ADDR) && (wGr_q ? s1_awvalid : s0_awvalid);
  assign s0_awready = (wState_q == W_ADDR) && !wGr_q && m_awready;
  assign s1_awready = (wState_q == W_ADDR) &&  wGr_q && m_awready;

  assign m_wdata   = wGr_q ? s1_wdata : s0_wdata;
  assign m_wstrb   = wGr_q ? s1_wstrb : s0_wstrb;
  assign m_wlast   = wGr_q ? s1_wlast : s0_wlast;
  assign m_wvalid  = (wState_q == W_DATA) && (wGr_q ? s1_wvalid : s0_wvalid);
  assign s0_wready = (wState_q == W_DATA) && !wGr_q && m_wready;
  assign s1_wready = (wState_q == W_DATA) &&  wGr_q && m_wready;

  assign m_bready  = (wState_q == W_RESP) && (wGr_q ? s1_bready : s0_bready);
  assign s0_bvalid = (wState_q == W_RESP) && !wGr_q && m_bvalid;
  assign s1_bvalid = (wState_q == W_RESP) &&  wGr_q && m_bvalid;
  assign s0_bid    = m_bid;
  assign s1_bid    = m_bid;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;

endmodule
